seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver.
// A prescaler paces a one-hot digit scan across NDIGITS BCD digits. New
// digit data is staged in a pending register and only moves into the
// display register at the end of a frame, so a frame never mixes old and
// new values. Segment, decimal-point and anode outputs are registered,
// with optional leading-zero blanking and optional active-low polarity.
module seg7_scan_driver #(
  parameter int NDIGITS    = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   load,
  input  logic                   blank_lz,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_start
);

  localparam int              CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              IW       = $clog2(NDIGITS);
  localparam logic            INV      = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   pend_bcd_q, pend_bcd_d;
  logic [NDIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [4*NDIGITS-1:0]   disp_bcd_q, disp_bcd_d;
  logic [NDIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   frame_start_q, frame_start_d;

  logic                   tick;
  logic                   wrap;
  logic [NDIGITS-1:0]     upper_zero;
  logic [3:0]             sel_bcd;
  logic                   sel_dp;
  logic                   sel_blank;
  logic [NDIGITS-1:0]     an_raw;
  logic [6:0]             seg_raw;

  // abcdefg pattern for one BCD value; anything above 9 shows a dash.
  function automatic logic [6:0] decode7(input logic [3:0] v);
    case (v)
      4'd0:    decode7 = 7'b1111110;
      4'd1:    decode7 = 7'b0110000;
      4'd2:    decode7 = 7'b1101101;
      4'd3:    decode7 = 7'b1111001;
      4'd4:    decode7 = 7'b0110011;
      4'd5:    decode7 = 7'b1011011;
      4'd6:    decode7 = 7'b1011111;
      4'd7:    decode7 = 7'b1110000;
      4'd8:    decode7 = 7'b1111111;
      4'd9:    decode7 = 7'b1111011;
      default: decode7 = 7'b0000001;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // upper_zero[k] is set when digit k and every digit above it are zero,
  // which is exactly the leading-zero blanking condition for digit k.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (disp_bcd_q[4*NDIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Prescaler, scan index, and the pending -> display handoff at frame end.
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    pend_bcd_d    = pend_bcd_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    disp_bcd_d    = disp_bcd_q;
    disp_dp_d     = disp_dp_q;
    frame_start_d = wrap;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    if (wrap && pend_valid_q) begin
      disp_bcd_d   = pend_bcd_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    // A load on the wrap tick still lands in pending after the old value
    // has committed, so it is shown in the following frame.
    if (load) begin
      pend_bcd_d   = bcd_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Select the active digit, decode it, apply blanking and output polarity.
  always_comb begin
    sel_bcd   = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_raw    = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_bcd   = disp_bcd_q[4*k +: 4];
        sel_dp    = disp_dp_q[k];
        sel_blank = blank_lz && (k != 0) && upper_zero[k];
        an_raw[k] = 1'b1;
      end
    end
    seg_raw = sel_blank ? 7'b0000000 : decode7(sel_bcd);
    seg_d   = seg_raw ^ {7{INV}};
    dp_d    = sel_dp ^ INV;
    an_d    = an_raw ^ {NDIGITS{INV}};
  end

  // State and output registers; reset leaves every output at its idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      disp_bcd_q    <= '0;
      disp_dp_q     <= '0;
      seg_q         <= {7{INV}};
      dp_q          <= INV;
      an_q          <= {NDIGITS{INV}};
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      disp_bcd_q    <= disp_bcd_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule
